// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates a single asynchronous SRAM between the
//                instruction-fetch port and the MEM-stage data port.
//                Fixed priority (data over fetch), with a multi-cycle
//                read / write strobe sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low

    input  logic        if_req_i,
    input  logic [15:0] if_addr_i,
    output logic [15:0] if_data_o,
    output logic        if_ready_o,

    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [15:0] mem_addr_i,
    input  logic [15:0] mem_wdata_i,
    output logic [15:0] mem_rdata_o,
    output logic        mem_ready_o,

    output logic        stall_req_o,

    output logic [17:0] sram_addr_o,
    output logic [15:0] sram_data_o,
    input  logic [15:0] sram_data_i,
    output logic        sram_data_oe_o,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_RD       = 3'd1;
    localparam logic [2:0] c_RD_DONE  = 3'd2;
    localparam logic [2:0] c_WR_SETUP = 3'd3;
    localparam logic [2:0] c_WR_PULSE = 3'd4;
    localparam logic [2:0] c_WR_HOLD  = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_sel_mem;     // 1 = data port owns the current access
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [17:0] r_sram_addr;
    logic [15:0] r_if_data;
    logic [15:0] r_mem_rdata;

    logic        w_grant;
    logic        w_grant_mem;
    logic        w_grant_we;
    logic        w_wr_phase;

    // Arbitration is only evaluated in IDLE; the data port always wins.
    always_comb begin
        w_grant     = (r_state == c_IDLE) && (mem_req_i || if_req_i);
        w_grant_mem = mem_req_i;
        w_grant_we  = mem_req_i && mem_we_i;
    end

    // Next-state sequencing; a granted access always runs to completion.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant) begin
                    w_next_state = w_grant_we ? c_WR_SETUP : c_RD;
                end
            end
            c_RD:       w_next_state = c_RD_DONE;
            c_RD_DONE:  w_next_state = c_IDLE;
            c_WR_SETUP: w_next_state = c_WR_PULSE;
            c_WR_PULSE: w_next_state = c_WR_HOLD;
            c_WR_HOLD:  w_next_state = c_IDLE;
            default:    w_next_state = c_IDLE;
        endcase
    end

    // State, grant latches, SRAM address register and read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_sel_mem   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_sram_addr <= 18'h00000;
            r_if_data   <= 16'h0000;
            r_mem_rdata <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_sel_mem   <= w_grant_mem;
                r_we        <= w_grant_we;
                r_addr      <= w_grant_mem ? mem_addr_i : if_addr_i;
                r_wdata     <= mem_wdata_i;
                r_sram_addr <= {2'b00, (w_grant_mem ? mem_addr_i : if_addr_i)};
            end
            // SRAM data has been stable for the whole RD cycle; sample on exit.
            if (r_state == c_RD) begin
                if (r_sel_mem) begin
                    r_mem_rdata <= sram_data_i;
                end else begin
                    r_if_data   <= sram_data_i;
                end
            end
        end
    end

    // Strobes decode directly from the registered state, so reset reaches
    // the pins immediately and OE/WE can never overlap.
    always_comb begin
        w_wr_phase     = (r_state == c_WR_SETUP) || (r_state == c_WR_PULSE) ||
                         (r_state == c_WR_HOLD);
        sram_ce_n_o    = 1'b1;
        sram_oe_n_o    = 1'b1;
        sram_we_n_o    = 1'b1;
        sram_data_oe_o = 1'b0;
        sram_data_o    = 16'h0000;
        if (r_state == c_RD) begin
            sram_ce_n_o = 1'b0;
            sram_oe_n_o = 1'b0;
        end
        if (w_wr_phase) begin
            sram_ce_n_o    = 1'b0;
            sram_data_oe_o = 1'b1;
            sram_data_o    = r_wdata;
            sram_we_n_o    = (r_state != c_WR_PULSE);
        end
    end

    // Ready pulses mark the final state of the owning port's access.
    always_comb begin
        if_ready_o  = (r_state == c_RD_DONE) && !r_sel_mem;
        mem_ready_o = ((r_state == c_RD_DONE) || (r_state == c_WR_HOLD)) && r_sel_mem;
        stall_req_o = (if_req_i && !if_ready_o) || (mem_req_i && !mem_ready_o);
    end

    assign sram_addr_o = r_sram_addr;
    assign if_data_o   = r_if_data;
    assign mem_rdata_o = r_mem_rdata;

    // r_addr and r_we are kept as the architectural grant record.
    logic w_unused;
    assign w_unused = ^{r_addr, r_we};

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a transaction-level
//                reference model (access length / phase index).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0;
    logic [15:0] if_addr_i = 16'h0;
    logic [15:0] if_data_o;
    logic        if_ready_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [15:0] mem_addr_i = 16'h0;
    logic [15:0] mem_wdata_i = 16'h0;
    logic [15:0] mem_rdata_o;
    logic        mem_ready_o;
    logic        stall_req_o;
    logic [17:0] sram_addr_o;
    logic [15:0] sram_data_o;
    logic [15:0] sram_data_i;
    logic        sram_data_oe_o;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;

    logic [15:0] sram_mem [0:255];
    assign sram_data_i = sram_mem[sram_addr_o[7:0]];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_data_o      (if_data_o),
        .if_ready_o     (if_ready_o),
        .mem_req_i      (mem_req_i),
        .mem_we_i       (mem_we_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_ready_o    (mem_ready_o),
        .stall_req_o    (stall_req_o),
        .sram_addr_o    (sram_addr_o),
        .sram_data_o    (sram_data_o),
        .sram_data_i    (sram_data_i),
        .sram_data_oe_o (sram_data_oe_o),
        .sram_ce_n_o    (sram_ce_n_o),
        .sram_oe_n_o    (sram_oe_n_o),
        .sram_we_n_o    (sram_we_n_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: an access is a number of phases (2 for read, 3 for
    // write); m_pos is the phase currently visible on the outputs.
    bit          m_busy;
    int          m_pos;
    bit          m_mem;
    bit          m_wr;
    logic [15:0] m_addr;
    logic [15:0] m_wd;
    logic [15:0] m_ifd;
    logic [15:0] m_md;
    logic [15:0] m_sa;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_pos = 0; m_mem = 1'b0; m_wr = 1'b0;
        m_addr = 16'h0; m_wd = 16'h0; m_ifd = 16'h0; m_md = 16'h0; m_sa = 16'h0;
    endtask

    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (mem_req_i) begin
                m_busy = 1'b1; m_pos = 0; m_mem = 1'b1; m_wr = mem_we_i;
                m_addr = mem_addr_i; m_wd = mem_wdata_i; m_sa = mem_addr_i;
            end else if (if_req_i) begin
                m_busy = 1'b1; m_pos = 0; m_mem = 1'b0; m_wr = 1'b0;
                m_addr = if_addr_i; m_sa = if_addr_i;
            end
        end else begin
            if (!m_wr && m_pos == 0) begin
                if (m_mem) m_md  = sram_mem[m_addr[7:0]];
                else       m_ifd = sram_mem[m_addr[7:0]];
            end
            if (m_pos == (m_wr ? 2 : 1)) m_busy = 1'b0;
            else                         m_pos++;
        end
    endtask

    task automatic check_all();
        bit e_rd, e_wr, e_done;
        e_rd   = m_busy && !m_wr && (m_pos == 0);
        e_wr   = m_busy && m_wr;
        e_done = m_busy && (m_pos == (m_wr ? 2 : 1));
        chk("oe_n",      32'(sram_oe_n_o),    32'(!e_rd));
        chk("we_n",      32'(sram_we_n_o),    32'(!(e_wr && m_pos == 1)));
        chk("data_oe",   32'(sram_data_oe_o), 32'(e_wr));
        if (e_rd || e_wr) chk("ce_n_active", 32'(sram_ce_n_o), 32'(0));
        else if (!m_busy) chk("ce_n_idle",   32'(sram_ce_n_o), 32'(1));
        chk("sram_addr", 32'(sram_addr_o),    32'({2'b00, m_sa}));
        if (e_wr || !rst) chk("sram_wdata", 32'(sram_data_o), 32'(m_wd));
        chk("if_ready",  32'(if_ready_o),     32'(e_done && !m_mem));
        chk("mem_ready", 32'(mem_ready_o),    32'(e_done && m_mem));
        chk("if_data",   32'(if_data_o),      32'(m_ifd));
        chk("mem_rdata", 32'(mem_rdata_o),    32'(m_md));
        chk("stall",     32'(stall_req_o),
            32'((if_req_i && !(e_done && !m_mem)) || (mem_req_i && !(e_done && m_mem))));
        chk("oe_we_excl", 32'(!(!sram_oe_n_o && !sram_we_n_o)), 32'(1));
        chk("doe_vs_oe",  32'(!(sram_data_oe_o && !sram_oe_n_o)), 32'(1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = 16'($urandom);
        sram_mem[8'h10] = 16'h6A05;
        sram_mem[8'h22] = 16'hBEEF;
        sram_mem[8'h44] = 16'hC0DE;
        model_reset();

        // Reset state, then release between edges.
        #1;
        check_all();
        tick();
        tick();
        #3 rst = 1'b1;
        tick();

        // Fetch from 0x0010.
        if_req_i = 1'b1; if_addr_i = 16'h0010;
        tick();
        chk("fetch_addr", 32'(sram_addr_o), 32'h00010);
        tick();
        chk("fetch_ready", 32'(if_ready_o), 32'(1));
        chk("fetch_data",  32'(if_data_o),  32'h6A05);
        if_req_i = 1'b0;
        tick();

        // Store 0x1234 to 0xBF00.
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'hBF00; mem_wdata_i = 16'h1234;
        tick();
        tick();
        chk("store_pulse_we", 32'(sram_we_n_o), 32'(0));
        chk("store_pulse_d",  32'(sram_data_o), 32'h1234);
        tick();
        chk("store_ready", 32'(mem_ready_o), 32'(1));
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        tick();

        // Simultaneous load and fetch: data port first.
        mem_req_i = 1'b1; mem_addr_i = 16'h0022; if_req_i = 1'b1; if_addr_i = 16'h0044;
        tick();
        tick();
        chk("both_mem_first", 32'(mem_ready_o), 32'(1));
        mem_req_i = 1'b0;
        tick();
        tick();
        tick();
        chk("both_if_ready", 32'(if_ready_o), 32'(1));
        chk("both_if_data",  32'(if_data_o),  32'hC0DE);
        if_req_i = 1'b0;
        tick();

        // Load request dropped during RD still completes.
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 16'h0010;
        tick();
        mem_req_i = 1'b0;
        tick();
        chk("drop_ready", 32'(mem_ready_o), 32'(1));
        chk("drop_data",  32'(mem_rdata_o), 32'h6A05);
        tick();

        // Reset asserted during WR_PULSE.
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'h0033; mem_wdata_i = 16'hA5A5;
        tick();
        tick();
        #2 rst = 1'b0;
        model_reset();
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        #1;
        check_all();
        tick();
        #3 rst = 1'b1;
        tick();
        tick();

        // Random mixed traffic.
        for (int n = 0; n < 400; n++) begin
            if_req_i    = ($urandom_range(0, 2) != 0);
            mem_req_i   = ($urandom_range(0, 2) == 0);
            mem_we_i    = 1'($urandom);
            if_addr_i   = 16'($urandom);
            mem_addr_i  = 16'($urandom);
            mem_wdata_i = 16'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
